// File: rtl/cmd_exec_ctrl.sv
// Command sequencer: pops one command, runs a single READ/WRITE memory
// transaction with an ack timeout, then pushes one status+data response.
// Strictly one command in flight.
module cmd_exec_ctrl #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_fifo_empty,
   output logic                       cmd_fifo_rd_en,
   input  logic [8+ADDR_W+DATA_W-1:0] cmd_fifo_rd_data,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ack,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       resp_fifo_full,
   output logic                       resp_fifo_wr_en,
   output logic [8+DATA_W-1:0]        resp_fifo_wr_data,
   output logic                       busy,
   output logic [7:0]                 err_count
);

   localparam int CMD_W  = 8 + ADDR_W + DATA_W;
   localparam int RESP_W = 8 + DATA_W;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0] OP_READ   = 8'h52;
   localparam logic [7:0] OP_WRITE  = 8'h57;
   localparam logic [7:0] ST_OK     = 8'h00;
   localparam logic [7:0] ST_BAD_OP = 8'h01;
   localparam logic [7:0] ST_TMO    = 8'h02;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RESP_W-1:0]   resp_q, resp_d;
   logic [7:0]          err_q, err_d;

   logic                pop;
   logic                push;
   logic                issue;
   logic [7:0]          opcode;

   assign opcode = cmd_fifo_rd_data[CMD_W-1 -: 8];

   // Next-state, command latch, timeout counter and response/error bookkeeping
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      err_d   = err_q;
      pop     = 1'b0;
      push    = 1'b0;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!cmd_fifo_empty) begin
               pop     = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            addr_d  = cmd_fifo_rd_data[DATA_W +: ADDR_W];
            wdata_d = cmd_fifo_rd_data[DATA_W-1:0];
            cnt_d   = '0;
            if (opcode == OP_READ || opcode == OP_WRITE) begin
               we_d    = (opcode == OP_WRITE);
               state_d = S_ISSUE;
            end else begin
               resp_d  = {ST_BAD_OP, {DATA_W{1'b0}}};
               state_d = S_RESP;
            end
         end
         S_ISSUE: begin
            issue = 1'b1;
            // ack is checked first so it wins over a same-cycle timeout
            if (mem_ack) begin
               resp_d  = {ST_OK, (we_q ? {DATA_W{1'b0}} : mem_rdata)};
               state_d = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               resp_d  = {ST_TMO, {DATA_W{1'b0}}};
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (!resp_fifo_full) begin
               push    = 1'b1;
               state_d = S_IDLE;
               if (resp_q[RESP_W-1 -: 8] != ST_OK && err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         resp_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   // Pop/push are gated by rst so a reset cycle never transfers data
   assign cmd_fifo_rd_en    = pop & ~rst;
   assign resp_fifo_wr_en   = push & ~rst;
   assign mem_req           = issue;
   assign mem_we            = issue & we_q;
   assign mem_addr          = issue ? addr_q : '0;
   assign mem_wdata         = issue ? wdata_q : '0;
   assign resp_fifo_wr_data = resp_q;
   assign busy              = (state_q != S_IDLE);
   assign err_count         = err_q;

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Bench for cmd_exec_ctrl: command FIFO and memory responder models, a
// response/err_count reference model, and directed scenarios.
module tb_cmd_exec_ctrl;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cmd_fifo_empty = 1'b1;
   logic                cmd_fifo_rd_en;
   logic [8+AW+DW-1:0]  cmd_fifo_rd_data = '0;
   logic                mem_req;
   logic                mem_we;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic                mem_ack = 1'b0;
   logic [DW-1:0]       mem_rdata = '0;
   logic                resp_fifo_full = 1'b0;
   logic                resp_fifo_wr_en;
   logic [8+DW-1:0]     resp_fifo_wr_data;
   logic                busy;
   logic [7:0]          err_count;

   cmd_exec_ctrl #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_fifo_empty(cmd_fifo_empty),
      .cmd_fifo_rd_en(cmd_fifo_rd_en),
      .cmd_fifo_rd_data(cmd_fifo_rd_data),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .resp_fifo_full(resp_fifo_full),
      .resp_fifo_wr_en(resp_fifo_wr_en),
      .resp_fifo_wr_data(resp_fifo_wr_data),
      .busy(busy),
      .err_count(err_count)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          dly;     // ISSUE cycle index of the ack, -1 = never
      logic [31:0] rdata;
   } cmd_t;

   typedef struct {
      logic [39:0] resp;
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          req;     // expected number of mem_req cycles
   } exp_t;

   cmd_t cmdq[$];
   exp_t expq[$];

   int          checks = 0;
   int          failures = 0;
   int          n_push = 0;
   int          rd_cyc = 0;
   int          wr_cyc = 0;
   int          last_req = 0;
   logic [39:0] last_resp = '0;
   logic        stray_ack = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Queue a command and derive its expected outcome from the opcode/ack plan
   task automatic add_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] wd,
                          input int dly, input logic [31:0] rd);
      cmd_t c;
      exp_t e;
      c = '{op, a, wd, dly, rd};
      cmdq.push_back(c);
      if (op == 8'h52 || op == 8'h57) begin
         if (dly >= 0 && dly < TMO) begin
            e.resp = {8'h00, ((op == 8'h52) ? rd : 32'h0)};
            e.req  = dly + 1;
         end else begin
            e.resp = {8'h02, 32'h0};
            e.req  = TMO;
         end
      end else begin
         e.resp = {8'h01, 32'h0};
         e.req  = 0;
      end
      e.we    = (op == 8'h57);
      e.addr  = a;
      e.wdata = wd;
      expq.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_push(input int target, input int budget);
      int k = 0;
      while (n_push < target && k < budget) begin
         step(1);
         k++;
      end
      chk("wait_push_budget", 64'(n_push >= target), 1);
   endtask

   // Environment: command FIFO with one-cycle read latency and memory responder
   initial begin
      cmd_t cur;
      int   cyc = 0;
      logic popped;
      cur = '{8'h00, 16'h0, 32'h0, -1, 32'h0};
      forever begin
         @(negedge clk);
         popped = cmd_fifo_rd_en;
         @(posedge clk);
         #1;
         if (popped && cmdq.size() > 0) begin
            cur = cmdq.pop_front();
            cmd_fifo_rd_data = {cur.op, cur.addr, cur.wdata};
         end
         cmd_fifo_empty = (cmdq.size() == 0);
         if (mem_req) begin
            mem_ack = (cur.dly == cyc);
            cyc++;
         end else begin
            mem_ack = stray_ack;
            cyc = 0;
         end
         mem_rdata = mem_ack ? cur.rdata : 32'h0BAD0BAD;
      end
   end

   // Compare process: every cycle against the reference model
   initial begin
      int   err_m = 0;
      int   req_cnt = 0;
      int   pops = 0;
      int   pushes = 0;
      int   cyc = 0;
      logic prev_rst = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            chk("no_push_in_reset", resp_fifo_wr_en, 0);
            chk("no_pop_in_reset", cmd_fifo_rd_en, 0);
            if (pops > pushes) begin
               e = expq.pop_front();
               pushes++;
            end
            err_m   = 0;
            req_cnt = 0;
         end else begin
            if (prev_rst) begin
               chk("post_reset_ctrl", {cmd_fifo_rd_en, mem_req, mem_we, resp_fifo_wr_en, busy}, 0);
               chk("post_reset_addr", mem_addr, 0);
               chk("post_reset_wdata", mem_wdata, 0);
               chk("post_reset_resp", resp_fifo_wr_data, 0);
            end
            chk("rd_en_while_empty", cmd_fifo_rd_en & cmd_fifo_empty, 0);
            chk("wr_en_while_full", resp_fifo_wr_en & resp_fifo_full, 0);
            chk("pop_while_busy", cmd_fifo_rd_en & busy, 0);
            chk("err_count", err_count, err_m);
            if (cmd_fifo_rd_en) begin
               chk("single_in_flight", 64'(pops - pushes), 0);
               pops++;
               rd_cyc = cyc;
            end
            if (mem_req) begin
               req_cnt++;
               if (expq.size() > 0) begin
                  chk("mem_we", mem_we, expq[0].we);
                  chk("mem_addr", mem_addr, expq[0].addr);
                  chk("mem_wdata", mem_wdata, expq[0].wdata);
               end else begin
                  chk("req_without_cmd", expq.size(), 1);
               end
            end
            if (resp_fifo_wr_en) begin
               pushes++;
               n_push++;
               wr_cyc = cyc;
               chk("push_has_expectation", 64'(expq.size() > 0), 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  chk("resp_data", resp_fifo_wr_data, e.resp);
                  chk("req_cycles", req_cnt, e.req);
                  if (e.resp[39:32] != 8'h00 && err_m < 255) err_m++;
               end
               last_resp = resp_fifo_wr_data;
               last_req  = req_cnt;
               req_cnt   = 0;
            end
         end
         prev_rst = rst;
      end
   end

   // Directed scenarios
   initial begin
      int k;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);

      // WRITE with ack on the fourth ISSUE cycle; rdata must not leak into the response
      add_cmd(8'h57, 16'h0010, 32'hDEADBEEF, 3, 32'hFFFF0000);
      wait_push(1, 50);
      chk("t1_resp", last_resp, 40'h00_00000000);
      chk("t1_req_cycles", last_req, 4);

      // READ acked in the first ISSUE cycle: rd_en T0 -> wr_en T3
      add_cmd(8'h52, 16'h0010, 32'h0, 0, 32'hCAFEF00D);
      wait_push(2, 50);
      chk("t2_resp", last_resp, 40'h00_CAFEF00D);
      chk("t2_latency", 64'(wr_cyc - rd_cyc), 3);

      // Bad opcode with stray acks outside ISSUE
      stray_ack = 1'b1;
      add_cmd(8'h41, 16'h0011, 32'h12345678, 0, 32'h0);
      wait_push(3, 50);
      stray_ack = 1'b0;
      chk("t3_resp", last_resp, 40'h01_00000000);
      chk("t3_req_cycles", last_req, 0);
      step(1);
      chk("t3_err", err_count, 1);

      // READ never acked -> timeout after exactly TMO request cycles
      add_cmd(8'h52, 16'h0020, 32'h0, -1, 32'h0);
      wait_push(4, 50);
      chk("t4_resp", last_resp, 40'h02_00000000);
      chk("t4_req_cycles", last_req, 8);
      step(1);
      chk("t4_err", err_count, 2);

      // Ack in the same cycle the timeout would fire: ack wins
      add_cmd(8'h52, 16'h0030, 32'h0, 7, 32'h12345678);
      wait_push(5, 50);
      chk("t4b_resp", last_resp, 40'h00_12345678);
      chk("t4b_req_cycles", last_req, 8);

      // Three commands queued while the response FIFO is full
      resp_fifo_full = 1'b1;
      add_cmd(8'h57, 16'h0100, 32'h11112222, 2, 32'h0);
      add_cmd(8'h52, 16'h0104, 32'h0, 1, 32'hA5A5A5A5);
      add_cmd(8'h00, 16'h0108, 32'h0, 0, 32'h0);
      step(20);
      chk("t5_no_push_while_full", n_push, 5);
      chk("t5_held_resp", resp_fifo_wr_data, 40'h00_00000000);
      resp_fifo_full = 1'b0;
      wait_push(8, 100);
      chk("t5_last_resp", last_resp, 40'h01_00000000);
      step(1);
      chk("t5_err", err_count, 3);

      // Reset while in ISSUE: command dropped, next one runs normally
      add_cmd(8'h52, 16'h0200, 32'h0, -1, 32'h0);
      k = 0;
      while (!mem_req && k < 20) begin
         step(1);
         k++;
      end
      chk("t6_reached_issue", mem_req, 1);
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      chk("t6_no_push", n_push, 8);
      chk("t6_err_cleared", err_count, 0);
      add_cmd(8'h57, 16'h0204, 32'h55AA55AA, 1, 32'h0);
      wait_push(9, 50);
      chk("t6_resp", last_resp, 40'h00_00000000);
      chk("t6_req_cycles", last_req, 2);

      // err_count saturates at 8'hFF
      for (int i = 0; i < 256; i++) begin
         add_cmd(8'hFF, 16'(i), 32'h0, 0, 32'h0);
      end
      wait_push(9 + 256, 256 * 6);
      step(2);
      chk("t7_err_saturated", err_count, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
